// File: rtl/voice_cmd_pkg.sv
// voice_cmd_pkg
//   Shared definitions for the air-purifier voice command parser:
//   frame FSM state encoding, default header/tail bytes and the
//   command opcodes understood by the executor.
package voice_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ARG  = 3'd2,
        ST_GET_CHK  = 3'd3,
        ST_GET_TAIL = 3'd4
    } state_e;

    localparam logic [7:0] DEF_HDR_BYTE  = 8'hAA;
    localparam logic [7:0] DEF_TAIL_BYTE = 8'h55;

    localparam logic [7:0] CMD_POWER_ON  = 8'h01;
    localparam logic [7:0] CMD_POWER_OFF = 8'h02;
    localparam logic [7:0] CMD_FAN       = 8'h03;
    localparam logic [7:0] CMD_AUTO      = 8'h04;

    // Largest fan level an 8'h03 argument may carry.
    localparam logic [7:0] FAN_ARG_MAX   = 8'd3;

endpackage

// File: rtl/over_edge_detect.sv
// over_edge_detect
//   Turns the UART receiver's byte-done level into a one-cycle strobe on
//   its rising edge, using a two-flop history (q1, q2).
//   Ports:
//     clk      - system clock
//     rst      - synchronous active-high reset
//     sig_i    - byte-done level from the UART receiver
//     strobe_o - one-cycle pulse, q1 & ~q2, qualified by armed_q
module over_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic strobe_o
);

    logic q1_q;
    logic q2_q;
    // armed_q stays low until the level has been seen low at least once,
    // so a level already high when reset releases is not taken as a new
    // byte; only its next genuine rising edge strobes.
    logic armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q    <= 1'b0;
            q2_q    <= 1'b0;
            armed_q <= ~sig_i;
        end else begin
            q1_q    <= sig_i;
            q2_q    <= q1_q;
            armed_q <= armed_q | ~sig_i;
        end
    end

    assign strobe_o = q1_q & ~q2_q & armed_q;

endmodule

// File: rtl/voice_cmd_parser.sv
// voice_cmd_parser
//   Parses 5-byte command frames (HDR, CMD, ARG, CHK, TAIL; CHK = CMD^ARG)
//   arriving byte by byte from a UART receiver and drives the purifier
//   controls.  Good frames pulse cmd_valid, rejected frames (bad checksum,
//   bad tail, unknown command, bad fan argument, inter-byte timeout) pulse
//   frame_err.  Pulses appear the cycle after the deciding strobe.
//   Ports:
//     clk, rst             - clock, synchronous active-high reset
//     message_in, over_in  - received byte and its byte-done level
//     cmd_valid, frame_err - one-cycle result pulses
//     cmd_code, cmd_arg    - CMD/ARG of the last accepted frame
//     power_on, fan_level, auto_mode - purifier control state
module voice_cmd_parser
    import voice_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd5000000,
    parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
    parameter logic [7:0]  TAIL_BYTE   = DEF_TAIL_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] message_in,
    input  logic       over_in,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       power_on,
    output logic [1:0] fan_level,
    output logic       auto_mode
);

    localparam int          CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] TMR_TERM = CNT_W'(TIMEOUT_CYC - 1);

    logic strobe;

    over_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (over_in),
        .strobe_o (strobe)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             bad_q, bad_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       code_q, code_d;
    logic [7:0]       carg_q, carg_d;
    logic             pwr_q, pwr_d;
    logic [1:0]       fan_q, fan_d;
    logic             auto_q, auto_d;
    logic             exec_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bad_q   <= 1'b0;
            cmd_q   <= '0;
            arg_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            carg_q  <= '0;
            pwr_q   <= 1'b0;
            fan_q   <= '0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bad_q   <= bad_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            carg_q  <= carg_d;
            pwr_q   <= pwr_d;
            fan_q   <= fan_d;
            auto_q  <= auto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        bad_d   = bad_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        carg_d  = carg_q;
        pwr_d   = pwr_q;
        fan_d   = fan_q;
        auto_d  = auto_q;
        exec_ok = 1'b0;

        if (strobe) begin
            // A byte always restarts the inter-byte timer, even when it
            // lands on the terminal count.
            tmr_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (message_in == HDR_BYTE) begin
                        state_d = ST_GET_CMD;
                        bad_d   = 1'b0;
                    end
                end
                ST_GET_CMD: begin
                    cmd_d   = message_in;
                    state_d = ST_GET_ARG;
                end
                ST_GET_ARG: begin
                    arg_d   = message_in;
                    state_d = ST_GET_CHK;
                end
                ST_GET_CHK: begin
                    // Checksum verdict is deferred until the tail so the
                    // frame length stays fixed either way.
                    bad_d   = (message_in != (cmd_q ^ arg_q));
                    state_d = ST_GET_TAIL;
                end
                ST_GET_TAIL: begin
                    state_d = ST_IDLE;
                    if (message_in == TAIL_BYTE && !bad_q) begin
                        case (cmd_q)
                            CMD_POWER_ON: begin
                                exec_ok = 1'b1;
                                pwr_d   = 1'b1;
                            end
                            CMD_POWER_OFF: begin
                                exec_ok = 1'b1;
                                pwr_d   = 1'b0;
                                fan_d   = 2'd0;
                                auto_d  = 1'b0;
                            end
                            CMD_FAN: begin
                                if (arg_q <= FAN_ARG_MAX) begin
                                    exec_ok = 1'b1;
                                    if (pwr_q) fan_d = arg_q[1:0];
                                end
                            end
                            CMD_AUTO: begin
                                exec_ok = 1'b1;
                                if (pwr_q) auto_d = arg_q[0];
                            end
                            default: exec_ok = 1'b0;
                        endcase
                        if (exec_ok) begin
                            valid_d = 1'b1;
                            code_d  = cmd_q;
                            carg_d  = arg_q;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                        // A header in the tail slot is likely the start of
                        // the next frame; resynchronise onto it.
                        if (message_in == HDR_BYTE && message_in != TAIL_BYTE) begin
                            state_d = ST_GET_CMD;
                            bad_d   = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_TERM) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            tmr_d   = '0;
        end else begin
            tmr_d = tmr_q + CNT_W'(1);
        end
    end

    assign cmd_valid = valid_q;
    assign frame_err = err_q;
    assign cmd_code  = code_q;
    assign cmd_arg   = carg_q;
    assign power_on  = pwr_q;
    assign fan_level = fan_q;
    assign auto_mode = auto_q;

endmodule

// File: tb/tb_voice_cmd_parser.sv
// tb_voice_cmd_parser
//   Drives byte frames into voice_cmd_parser and compares every cycle's
//   outputs with a frame-level reference model: bytes after a header are
//   collected into a queue and judged as a whole once four have arrived;
//   a frame left open for TIMEOUT sample periods without a byte is failed.
module tb_voice_cmd_parser;

    localparam int         T    = 1000;
    localparam logic [7:0] HDR  = 8'hAA;
    localparam logic [7:0] TAIL = 8'h55;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] message_in;
    logic       over_in;
    logic       cmd_valid, frame_err, power_on, auto_mode;
    logic [7:0] cmd_code, cmd_arg;
    logic [1:0] fan_level;

    voice_cmd_parser #(.TIMEOUT_CYC(T), .HDR_BYTE(HDR), .TAIL_BYTE(TAIL)) dut (
        .clk        (clk),
        .rst        (rst),
        .message_in (message_in),
        .over_in    (over_in),
        .cmd_valid  (cmd_valid),
        .frame_err  (frame_err),
        .cmd_code   (cmd_code),
        .cmd_arg    (cmd_arg),
        .power_on   (power_on),
        .fan_level  (fan_level),
        .auto_mode  (auto_mode)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    logic [7:0] frm[$];
    bit         m_open;
    int         m_since;
    bit         pend;
    int         pend_age;
    logic [7:0] pend_b;
    bit         e_valid, e_err;
    logic [7:0] m_code, m_arg;
    bit         m_pwr, m_auto;
    logic [1:0] m_fan;

    task automatic model_reset();
        frm.delete();
        m_open = 0; m_since = 0; pend = 0;
        m_code = 0; m_arg = 0; m_pwr = 0; m_fan = 0; m_auto = 0;
    endtask

    task automatic decide(input logic [7:0] b);
        logic [7:0] c, a, k, t;
        bit ok;
        m_since = 0;
        if (!m_open) begin
            if (b == HDR) begin m_open = 1; frm.delete(); end
            return;
        end
        frm.push_back(b);
        if (frm.size() < 4) return;
        c = frm[0]; a = frm[1]; k = frm[2]; t = frm[3];
        frm.delete();
        m_open = 0;
        ok = 0;
        if (t == TAIL && k == (c ^ a)) begin
            if (c == 8'h01) begin ok = 1; m_pwr = 1; end
            else if (c == 8'h02) begin ok = 1; m_pwr = 0; m_fan = 0; m_auto = 0; end
            else if (c == 8'h03 && a <= 3) begin ok = 1; if (m_pwr) m_fan = a[1:0]; end
            else if (c == 8'h04) begin ok = 1; if (m_pwr) m_auto = a[0]; end
        end else if (t != TAIL && t == HDR) begin
            m_open = 1;
        end
        if (ok) begin e_valid = 1; m_code = c; m_arg = a; end
        else e_err = 1;
    endtask

    // One clock: advance the model for the edge just taken and compare.
    task automatic tick();
        logic r;
        bit   dec;
        r = rst;
        @(negedge clk);
        e_valid = 0; e_err = 0; dec = 0;
        if (r) model_reset();
        else begin
            if (pend) begin
                pend_age++;
                if (pend_age == 2) begin pend = 0; decide(pend_b); dec = 1; end
            end
            if (!dec && m_open) begin
                m_since++;
                if (m_since == T) begin e_err = 1; m_open = 0; frm.delete(); end
            end
        end
        chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, e_valid});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e_err});
        chk("ctrl", {12'd0, cmd_code, cmd_arg, power_on, fan_level, auto_mode},
                    {12'd0, m_code, m_arg, m_pwr, m_fan, m_auto});
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        message_in = b;
        over_in    = 1'b1;
        pend = 1; pend_age = 0; pend_b = b;
        repeat (hi) tick();
        over_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, 2 + int'($urandom_range(0, 2)), 1 + int'($urandom_range(0, 2)));
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a,
                         input logic [7:0] k, input logic [7:0] t);
        sb(HDR); sb(c); sb(a); sb(k); sb(t);
    endtask

    initial begin
        logic [7:0] c, a, k, t;
        int sel;
        rst = 1'b1; over_in = 1'b0; message_in = 8'h00;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // basic power on, fan, rejected fan argument
        frame(8'h01, 8'h00, 8'h01, TAIL);
        chk("pwr_after_on", {31'd0, power_on}, 32'd1);
        chk("code_after_on", {24'd0, cmd_code}, 32'h01);
        frame(8'h03, 8'h02, 8'h01, TAIL);
        frame(8'h03, 8'h05, 8'h06, TAIL);
        chk("fan_kept", {30'd0, fan_level}, 32'd2);

        // bad checksum then a good auto frame
        frame(8'h04, 8'h01, 8'h00, TAIL);
        chk("auto_kept", {31'd0, auto_mode}, 32'd0);
        frame(8'h04, 8'h01, 8'h05, TAIL);
        chk("auto_set", {31'd0, auto_mode}, 32'd1);

        // timeout after header + cmd, then stray byte ignored in idle
        sb(HDR); sb(8'h01);
        repeat (T + 5) tick();
        sb(8'h00);
        frame(8'h03, 8'h01, 8'h02, TAIL);
        chk("fan_after_timeout", {30'd0, fan_level}, 32'd1);

        // wrong tail that is a header resynchronises
        sb(HDR); sb(8'h01); sb(8'h00); sb(8'h01);
        sb(HDR); sb(8'h01); sb(8'h00); sb(8'h01); sb(TAIL);

        // reset mid-frame, over_in held high across release
        sb(HDR); sb(8'h01); sb(8'h00);
        rst = 1'b1; over_in = 1'b1; message_in = HDR;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("pwr_after_rst", {31'd0, power_on}, 32'd0);
        over_in = 1'b0;
        repeat (2) tick();
        frame(8'h01, 8'h00, 8'h01, TAIL);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 11));
            if (sel == 0) begin
                sb(8'($urandom));
            end else if (sel == 1) begin
                // gap around the timeout boundary: strobe-wins and just-late
                send_byte(HDR, 2, T - 3 + int'($urandom_range(0, 2)));
                sb(8'h01); sb(8'h00); sb(8'h01); sb(TAIL);
            end else begin
                c = 8'($urandom_range(0, 5));
                a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
                k = c ^ a;
                t = TAIL;
                if ($urandom_range(0, 7) == 0) k = k ^ 8'($urandom_range(1, 255));
                if ($urandom_range(0, 7) == 0) t = ($urandom_range(0, 1) == 1) ? HDR : 8'($urandom);
                frame(c, a, k, t);
            end
        end
        repeat (T + 5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
